// File: rtl/phy_rx_decode.sv
// RGMII receive decoder: turns IDDR nibble pairs into an AXI-Stream byte flow with
// preamble/SFD stripping, error and length policing, and in-band link status capture.
module phy_rx_decode #(
  parameter int unsigned MAX_FRAME_LEN = 1522
) (
  input  logic       phy_rx_clk,
  input  logic       phy_rx_rst,
  input  logic [3:0] rxd_rise,
  input  logic [3:0] rxd_fall,
  input  logic       rx_ctl_rise,
  input  logic       rx_ctl_fall,
  output logic [7:0] rx_axis_tdata,
  output logic       rx_axis_tvalid,
  output logic       rx_axis_tlast,
  output logic       rx_axis_tuser,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       full_duplex,
  output logic       frame_err_pulse
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME_LEN);
  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DROP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  byte_q, byte_d;
  logic        dv_q, dv_d;
  logic        er_q, er_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        tuser_q, tuser_d;
  logic        err_pulse_q, err_pulse_d;
  logic        link_up_q, link_up_d;
  logic [1:0]  link_speed_q, link_speed_d;
  logic        full_duplex_q, full_duplex_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    byte_d        = {rxd_fall, rxd_rise};
    dv_d          = rx_ctl_rise;
    er_d          = rx_ctl_rise ^ rx_ctl_fall;
    state_d       = state_q;
    hold_d        = hold_q;
    hold_vld_d    = hold_vld_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    tdata_d       = tdata_q;
    tvalid_d      = 1'b0;
    tlast_d       = 1'b0;
    tuser_d       = 1'b0;
    err_pulse_d   = 1'b0;
    link_up_d     = link_up_q;
    link_speed_d  = link_speed_q;
    full_duplex_d = full_duplex_q;

    // Per-frame bookkeeping only matters inside DATA; holding it clear elsewhere
    // guarantees a clean start on every entry.
    if (state_q != S_DATA) begin
      hold_vld_d = 1'b0;
      cnt_d      = '0;
      err_d      = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (dv_q) begin
          if (byte_q == PRE_BYTE) begin
            state_d = S_PREAMBLE;
          end else if (byte_q == SFD_BYTE) begin
            state_d = S_DATA;
          end else begin
            state_d     = S_DROP;
            err_pulse_d = 1'b1;
          end
        end else if (!er_q) begin
          link_up_d     = byte_q[0];
          link_speed_d  = byte_q[2:1];
          full_duplex_d = byte_q[3];
        end
      end

      S_PREAMBLE: begin
        if (!dv_q) begin
          state_d = S_IDLE;
        end else if (!er_q && byte_q == PRE_BYTE) begin
          state_d = S_PREAMBLE;
        end else if (!er_q && byte_q == SFD_BYTE) begin
          state_d = S_DATA;
        end else begin
          state_d     = S_DROP;
          err_pulse_d = 1'b1;
        end
      end

      S_DATA: begin
        if (dv_q) begin
          if (cnt_q == MAX_LEN) begin
            // Oversize: close the frame on the held byte and discard the rest.
            tdata_d     = hold_q;
            tvalid_d    = 1'b1;
            tlast_d     = 1'b1;
            tuser_d     = 1'b1;
            err_pulse_d = 1'b1;
            hold_vld_d  = 1'b0;
            state_d     = S_DROP;
          end else begin
            if (hold_vld_q) begin
              tdata_d  = hold_q;
              tvalid_d = 1'b1;
            end
            hold_d     = byte_q;
            hold_vld_d = 1'b1;
            cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            err_d      = err_q | er_q;
          end
        end else begin
          if (hold_vld_q) begin
            tdata_d     = hold_q;
            tvalid_d    = 1'b1;
            tlast_d     = 1'b1;
            tuser_d     = err_q;
            err_pulse_d = err_q;
          end else begin
            // SFD followed directly by end of carrier: nothing to deliver.
            err_pulse_d = 1'b1;
          end
          hold_vld_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      S_DROP: begin
        if (!dv_q) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge phy_rx_clk or posedge phy_rx_rst) begin
    if (phy_rx_rst) begin
      // NOTE: the hold register is reset too, so a stale byte can never leak into a post-reset frame.
      state_q       <= S_IDLE;
      byte_q        <= '0;
      dv_q          <= 1'b0;
      er_q          <= 1'b0;
      hold_q        <= '0;
      hold_vld_q    <= 1'b0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tuser_q       <= 1'b0;
      err_pulse_q   <= 1'b0;
      link_up_q     <= 1'b0;
      link_speed_q  <= 2'b00;
      full_duplex_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      byte_q        <= byte_d;
      dv_q          <= dv_d;
      er_q          <= er_d;
      hold_q        <= hold_d;
      hold_vld_q    <= hold_vld_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      tuser_q       <= tuser_d;
      err_pulse_q   <= err_pulse_d;
      link_up_q     <= link_up_d;
      link_speed_q  <= link_speed_d;
      full_duplex_q <= full_duplex_d;
    end
  end

  assign rx_axis_tdata   = tdata_q;
  assign rx_axis_tvalid  = tvalid_q;
  assign rx_axis_tlast   = tlast_q;
  assign rx_axis_tuser   = tuser_q;
  assign frame_err_pulse = err_pulse_q;
  assign link_up         = link_up_q;
  assign link_speed      = link_speed_q;
  assign full_duplex     = full_duplex_q;

endmodule

// File: tb/tb_phy_rx_decode.sv
// Directed bench for phy_rx_decode: frame table, status table, and hand sequences
// for latency, back-to-back frames and mid-frame reset.
module tb_phy_rx_decode;

  localparam int          MAX_LEN   = 64;
  localparam logic [7:0]  IDLE_BYTE = 8'h0D;

  logic       phy_rx_clk = 1'b0;
  logic       phy_rx_rst;
  logic [3:0] rxd_rise, rxd_fall;
  logic       rx_ctl_rise, rx_ctl_fall;
  logic [7:0] rx_axis_tdata;
  logic       rx_axis_tvalid, rx_axis_tlast, rx_axis_tuser;
  logic       link_up;
  logic [1:0] link_speed;
  logic       full_duplex;
  logic       frame_err_pulse;

  phy_rx_decode #(.MAX_FRAME_LEN(MAX_LEN)) dut (
    .phy_rx_clk      (phy_rx_clk),
    .phy_rx_rst      (phy_rx_rst),
    .rxd_rise        (rxd_rise),
    .rxd_fall        (rxd_fall),
    .rx_ctl_rise     (rx_ctl_rise),
    .rx_ctl_fall     (rx_ctl_fall),
    .rx_axis_tdata   (rx_axis_tdata),
    .rx_axis_tvalid  (rx_axis_tvalid),
    .rx_axis_tlast   (rx_axis_tlast),
    .rx_axis_tuser   (rx_axis_tuser),
    .link_up         (link_up),
    .link_speed      (link_speed),
    .full_duplex     (full_duplex),
    .frame_err_pulse (frame_err_pulse)
  );

  always #5 phy_rx_clk = ~phy_rx_clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  typedef struct {
    string      name;
    int         pre_len;
    logic [7:0] sfd;
    int         n_bytes;
    int         er_idx;
    int         exp_beats;
    logic       exp_user;
    int         exp_pulses;
  } frame_vec_t;

  typedef struct {
    logic       dv;
    logic       er;
    logic [7:0] b;
    logic       lu;
    logic [1:0] sp;
    logic       fd;
  } stat_vec_t;

  beat_t beats[$];
  int    pulses   = 0;
  int    tests    = 0;
  int    failures = 0;

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge phy_rx_clk) begin
    if (!phy_rx_rst) begin
      if (rx_axis_tvalid) beats.push_back('{rx_axis_tdata, rx_axis_tlast, rx_axis_tuser});
      if (frame_err_pulse) pulses++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] b);
    rxd_rise    = b[3:0];
    rxd_fall    = b[7:4];
    rx_ctl_rise = dv;
    rx_ctl_fall = dv ^ er;
    @(posedge phy_rx_clk);
    #1;
  endtask

  task automatic send_frame(input int pre_len, input logic [7:0] sfd, input int n_bytes,
                            input int er_idx, input int n_idle);
    for (int i = 0; i < pre_len; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, sfd);
    for (int i = 0; i < n_bytes; i++) drive(1'b1, (i == er_idx), 8'(i));
    for (int i = 0; i < n_idle; i++) drive(1'b0, 1'b0, IDLE_BYTE);
  endtask

  task automatic check_frame(input string tag, input int b0, input int p0, input int exp_beats,
                             input logic exp_user, input int exp_pulses);
    int    n;
    beat_t bt;
    n = beats.size() - b0;
    check($sformatf("%s beats", tag), n, exp_beats);
    check($sformatf("%s pulses", tag), pulses - p0, exp_pulses);
    for (int i = 0; i < exp_beats && i < n; i++) begin
      bt = beats[b0 + i];
      check($sformatf("%s b%0d data", tag, i), bt.data, 8'(i));
      check($sformatf("%s b%0d last", tag, i), bt.last, (i == exp_beats - 1));
      check($sformatf("%s b%0d user", tag, i), bt.user, (i == exp_beats - 1) && exp_user);
    end
  endtask

  frame_vec_t fvec[10];
  stat_vec_t  svec[5];

  initial begin
    int    b0, p0;
    beat_t bt;

    fvec[0] = '{"good64",    7, 8'hD5, 64,  -1, 64, 1'b0, 0};
    fvec[1] = '{"er_b10",    7, 8'hD5, 64,  10, 64, 1'b1, 1};
    fvec[2] = '{"over100",   7, 8'hD5, 100, -1, 64, 1'b1, 1};
    fvec[3] = '{"over65",    7, 8'hD5, 65,  -1, 64, 1'b1, 1};
    fvec[4] = '{"len63",     7, 8'hD5, 63,  -1, 63, 1'b0, 0};
    fvec[5] = '{"len1",      7, 8'hD5, 1,   -1, 1,  1'b0, 0};
    fvec[6] = '{"len0",      7, 8'hD5, 0,   -1, 0,  1'b0, 1};
    fvec[7] = '{"no_pre",    0, 8'hD5, 5,   -1, 5,  1'b0, 0};
    fvec[8] = '{"first_aa",  0, 8'hAA, 5,   -1, 0,  1'b0, 1};
    fvec[9] = '{"bad_pre",   3, 8'h5A, 5,   -1, 0,  1'b0, 1};

    svec[0] = '{1'b0, 1'b0, 8'h0D, 1'b1, 2'b10, 1'b1};
    svec[1] = '{1'b0, 1'b0, 8'h02, 1'b0, 2'b01, 1'b0};
    svec[2] = '{1'b0, 1'b0, 8'h09, 1'b1, 2'b00, 1'b1};
    svec[3] = '{1'b0, 1'b1, 8'h06, 1'b1, 2'b00, 1'b1};
    svec[4] = '{1'b0, 1'b0, 8'h0D, 1'b1, 2'b10, 1'b1};

    // Reset state
    phy_rx_rst  = 1'b1;
    rxd_rise    = 4'h0;
    rxd_fall    = 4'h0;
    rx_ctl_rise = 1'b0;
    rx_ctl_fall = 1'b0;
    repeat (3) @(posedge phy_rx_clk);
    #1;
    check("reset outputs",
          {rx_axis_tdata, rx_axis_tvalid, rx_axis_tlast, rx_axis_tuser, frame_err_pulse,
           link_up, link_speed, full_duplex}, 32'h0);
    phy_rx_rst = 1'b0;

    // In-band status; each vector is followed by a carrier-extend cycle that must not update
    for (int i = 0; i < 5; i++) begin
      drive(svec[i].dv, svec[i].er, svec[i].b);
      drive(1'b0, 1'b1, 8'h00);
      check($sformatf("status%0d", i), {link_up, link_speed, full_duplex},
            {svec[i].lu, svec[i].sp, svec[i].fd});
    end
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, IDLE_BYTE);

    // Frame table
    for (int v = 0; v < 10; v++) begin
      b0 = beats.size();
      p0 = pulses;
      send_frame(fvec[v].pre_len, fvec[v].sfd, fvec[v].n_bytes, fvec[v].er_idx, 4);
      check_frame(fvec[v].name, b0, p0, fvec[v].exp_beats, fvec[v].exp_user, fvec[v].exp_pulses);
    end
    check("status held", {link_up, link_speed, full_duplex}, {1'b1, 2'b10, 1'b1});

    // Latency: first data byte appears two edges after it is sampled
    b0 = beats.size();
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    drive(1'b1, 1'b0, 8'hA1);
    drive(1'b1, 1'b0, 8'hB2);
    check("lat early tvalid", rx_axis_tvalid, 1'b0);
    drive(1'b1, 1'b0, 8'hC3);
    check("lat tvalid", rx_axis_tvalid, 1'b1);
    check("lat tdata", rx_axis_tdata, 8'hA1);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, IDLE_BYTE);
    check("lat beats", beats.size() - b0, 3);
    if (beats.size() - b0 == 3) begin
      bt = beats[b0 + 2];
      check("lat last data", bt.data, 8'hC3);
      check("lat last flag", bt.last, 1'b1);
    end

    // Back-to-back frames with a single idle cycle between them
    b0 = beats.size();
    p0 = pulses;
    send_frame(7, 8'hD5, 3, -1, 1);
    send_frame(2, 8'hD5, 3, -1, 4);
    check("b2b beats", beats.size() - b0, 6);
    check("b2b pulses", pulses - p0, 0);
    for (int i = 0; i < 6 && i < beats.size() - b0; i++) begin
      bt = beats[b0 + i];
      check($sformatf("b2b b%0d data", i), bt.data, 8'(i % 3));
      check($sformatf("b2b b%0d last", i), bt.last, (i % 3 == 2));
    end

    // Reset pulsed during byte 20 of a frame
    b0 = beats.size();
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 8'(i));
    @(negedge phy_rx_clk);
    #1;
    phy_rx_rst = 1'b1;
    #1;
    check("rst mid outputs",
          {rx_axis_tdata, rx_axis_tvalid, rx_axis_tlast, rx_axis_tuser, frame_err_pulse,
           link_up, link_speed, full_duplex}, 32'h0);
    check("rst pre beats", beats.size() - b0, 18);
    for (int i = b0; i < beats.size(); i++) begin
      bt = beats[i];
      check($sformatf("rst pre b%0d nolast", i - b0), bt.last, 1'b0);
    end
    rxd_rise    = 4'h4;
    rxd_fall    = 4'h1;
    rx_ctl_rise = 1'b1;
    rx_ctl_fall = 1'b1;
    repeat (2) @(posedge phy_rx_clk);
    #1;
    phy_rx_rst = 1'b0;
    b0 = beats.size();
    p0 = pulses;
    for (int i = 21; i < 31; i++) drive(1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, IDLE_BYTE);
    check("rst tail beats", beats.size() - b0, 0);
    check("rst tail pulses", pulses - p0, 1);
    check("rst status relearn", {link_up, link_speed, full_duplex}, {1'b1, 2'b10, 1'b1});
    b0 = beats.size();
    p0 = pulses;
    send_frame(7, 8'hD5, 64, -1, 4);
    check_frame("post_rst", b0, p0, 64, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
